// File: rtl/fil2dma_burst_ctrl.sv
// Drain-side burst controller for the fil2dma fb_fifo: tracks occupancy and pops
// bursts toward the DMA write channel. Optional stats counters: FIL2DMA_BURST_STATS_EN.
module fil2dma_burst_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 32,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic             flush,
  input  logic             fifo_push,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_out,
  output logic             fifo_pop,
  output logic             dma_valid,
  output logic [WIDTH-1:0] dma_data,
  output logic             dma_last,
  input  logic             dma_ready,
  output logic             busy
`ifdef FIL2DMA_BURST_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat_bursts,
  output logic [15:0]      stat_timeouts
`endif
);

  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT);

  localparam logic [OCC_W-1:0]  OCC_BURST = OCC_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  LEN_MAX   = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [OCC_W-1:0]   occ;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [CNT_W-1:0]   len;
  logic [CNT_W-1:0]   popped;
  logic [CNT_W-1:0]   start_len;
  logic               start, start_tmo;
  logic               occ_nz, occ_burst, push_acc, last_pop, last_hs;

  assign occ_nz    = (occ != '0);
  assign occ_burst = (occ >= OCC_BURST);
  assign push_acc  = fifo_push && !fifo_full;
  assign last_pop  = ((popped + CNT_ONE) == len);
  assign last_hs   = dma_valid && dma_ready && dma_last;
  assign busy      = (state != IDLE);

  // A new beat may be fetched only when the output register is free or draining this cycle.
  assign fifo_pop = (state == BURST) && (popped < len) && !fifo_empty
                    && (!dma_valid || dma_ready);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt = state;
    start     = 1'b0;
    start_tmo = 1'b0;
    start_len = len;
    unique case (state)
      IDLE: begin
        if (cfg_en && occ_burst) begin
          start     = 1'b1;
          start_len = LEN_MAX;
        end else if (flush && occ_nz) begin
          start     = 1'b1;
          start_len = occ_burst ? LEN_MAX : CNT_W'(occ);
        end else if (cfg_en && occ_nz && (idle_cnt == IDLE_MAX)) begin
          start     = 1'b1;
          start_tmo = 1'b1;
          start_len = CNT_W'(occ);
        end
        if (start) state_nxt = BURST;
      end
      BURST: if (fifo_pop && last_pop) state_nxt = DRAIN;
      DRAIN: if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state    <= IDLE;
      occ      <= '0;
      idle_cnt <= '0;
      len      <= '0;
      popped   <= '0;
    end else begin
      state <= state_nxt;

      unique case ({push_acc, fifo_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase

      // Partial-burst timer only runs while a short, non-empty backlog waits in IDLE.
      if (state != IDLE || start || !occ_nz || occ_burst) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      if (start) begin
        len    <= start_len;
        popped <= '0;
      end else if (fifo_pop) begin
        popped <= popped + CNT_ONE;
      end
    end
  end

  // Output beat register: loads on pop, holds under backpressure, empties when accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_valid <= 1'b0;
      dma_data  <= '0;
      dma_last  <= 1'b0;
    end else if (fifo_pop) begin
      dma_valid <= 1'b1;
      dma_data  <= fifo_out;
      dma_last  <= last_pop;
    end else if (dma_ready) begin
      dma_valid <= 1'b0;
      dma_last  <= 1'b0;
    end
  end

`ifdef FIL2DMA_BURST_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bursts   <= '0;
      stat_timeouts <= '0;
    end else if (stat_clr) begin
      stat_bursts   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (start)     stat_bursts   <= stat_bursts + 16'd1;
      if (start_tmo) stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fil2dma_burst_ctrl.sv
// Self-checking bench for fil2dma_burst_ctrl: a queue-based fb_fifo model feeds the DUT and
// a scoreboard checks every DMA beat, burst length and hold-under-backpressure.
module tb_fil2dma_burst_ctrl;

  localparam int WIDTH     = 4;
  localparam int DEPTH     = 32;
  localparam int BURST_LEN = 8;
  localparam int TIMEOUT   = 64;

  logic             clk;
  logic             rst_n;
  logic             cfg_en;
  logic             flush;
  logic             fifo_push;
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_out;
  logic             fifo_pop;
  logic             dma_valid;
  logic [WIDTH-1:0] dma_data;
  logic             dma_last;
  logic             dma_ready;
  logic             busy;
`ifdef FIL2DMA_BURST_STATS_EN
  logic             stat_clr;
  logic [15:0]      stat_bursts;
  logic [15:0]      stat_timeouts;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];
  int               bursts_q[$];
  int               beat_cnt, hs_cnt, valid_cycles, data_err, stall_err, occ_err;
  bit               hold_pend;
  logic [WIDTH-1:0] hold_data;
  logic             hold_last;

  fil2dma_burst_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .flush(flush),
    .fifo_push(fifo_push), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_out(fifo_out), .fifo_pop(fifo_pop), .dma_valid(dma_valid),
    .dma_data(dma_data), .dma_last(dma_last), .dma_ready(dma_ready), .busy(busy)
`ifdef FIL2DMA_BURST_STATS_EN
    , .stat_clr(stat_clr), .stat_bursts(stat_bursts), .stat_timeouts(stat_timeouts)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // fb_fifo model (show-ahead, drops pushes while full) plus DMA-side scoreboard.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      exp_q.delete();
      beat_cnt   = 0;
      hold_pend  = 0;
      fifo_out   <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (hold_pend && (!dma_valid || dma_data !== hold_data || dma_last !== hold_last))
        stall_err++;
      hold_pend = dma_valid && !dma_ready;
      hold_data = dma_data;
      hold_last = dma_last;
      if (dma_valid) valid_cycles++;
      if (dma_valid && dma_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0 || exp_q[0] !== dma_data) data_err++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        beat_cnt++;
        if (dma_last) begin
          bursts_q.push_back(beat_cnt);
          beat_cnt = 0;
        end
      end
      if (fifo_push && !fifo_full) begin
        fq.push_back(fifo_din);
        exp_q.push_back(fifo_din);
      end
      if (fifo_pop && fq.size() != 0) void'(fq.pop_front());
      fifo_out   <= (fq.size() != 0) ? fq[0] : '0;
      fifo_empty <= (fq.size() == 0);
      fifo_full  <= (fq.size() == DEPTH);
    end
  end

  always @(negedge clk) begin
    if (rst_n && int'(dut.occ) != fq.size()) occ_err++;
  end

  task automatic clear_logs();
    bursts_q.delete();
    hs_cnt = 0; valid_cycles = 0; data_err = 0; stall_err = 0; occ_err = 0;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_push = 1'b1;
      fifo_din  = WIDTH'($urandom);
      @(negedge clk);
    end
    fifo_push = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_bursts(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (bursts_q.size() >= n) ok = 1;
      else @(negedge clk);
    end
    if (bursts_q.size() >= n) ok = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (dma_valid !== 1'b0 || dma_last !== 1'b0 || dma_data !== '0) begin
      bad++; $display("FAIL reset_dma: valid=%b last=%b data=%h want 0/0/0", dma_valid, dma_last, dma_data); end
    total++; if (fifo_pop !== 1'b0) begin bad++; $display("FAIL reset_pop: got %b want 0", fifo_pop); end
    total++; if (dut.occ !== '0) begin bad++; $display("FAIL reset_occ: got %0d want 0", dut.occ); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || dma_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release: busy=%b valid=%b want 0/0", busy, dma_valid); end
  endtask

  task automatic test_full_burst();
    clear_logs();
    cfg_en = 1'b1; dma_ready = 1'b1;
    for (int i = 0; i < BURST_LEN; i++) begin
      fifo_push = 1'b1; fifo_din = WIDTH'(i + 1);
      @(negedge clk);
    end
    fifo_push = 1'b0;
    total++; if (fifo_pop !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL full_pop_early: pop=%b busy=%b want 0/0", fifo_pop, busy); end
    @(negedge clk);
    total++; if (fifo_pop !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL full_pop_start: pop=%b busy=%b want 1/1", fifo_pop, busy); end
    for (int k = 1; k <= BURST_LEN; k++) begin
      @(negedge clk);
      total++;
      if (dma_valid !== 1'b1 || dma_data !== WIDTH'(k) || dma_last !== (k == BURST_LEN)) begin
        bad++; $display("FAIL full_beat%0d: valid=%b data=%h last=%b want 1/%h/%b",
                        k, dma_valid, dma_data, dma_last, WIDTH'(k), k == BURST_LEN);
      end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || dma_valid !== 1'b0 || dut.occ !== '0) begin
      bad++; $display("FAIL full_end: busy=%b valid=%b occ=%0d want 0/0/0", busy, dma_valid, dut.occ); end
    total++; if (bursts_q.size() != 1 || bursts_q[0] != BURST_LEN || data_err != 0) begin
      bad++; $display("FAIL full_bursts: count=%0d data_err=%0d want 1/0", bursts_q.size(), data_err); end
  endtask

  task automatic test_timeout();
    int first_busy = -1;
    bit ok;
`ifdef FIL2DMA_BURST_STATS_EN
    logic [15:0] tmo0 = stat_timeouts;
`endif
    clear_logs();
    cfg_en = 1'b1; dma_ready = 1'b1;
    fifo_push = 1'b1; fifo_din = WIDTH'($urandom);
    for (int k = 1; k <= TIMEOUT + 40; k++) begin
      @(negedge clk);
      if (k < 3) fifo_din = WIDTH'($urandom);
      else fifo_push = 1'b0;
      if (busy && first_busy < 0) first_busy = k;
    end
    wait_bursts(1, 50, ok);
    total++; if (first_busy != TIMEOUT + 1) begin
      bad++; $display("FAIL tmo_start: got cycle %0d want %0d", first_busy, TIMEOUT + 1); end
    total++; if (!ok || bursts_q[0] != 3) begin
      bad++; $display("FAIL tmo_len: got %0d bursts (first %0d) want 1 of 3", bursts_q.size(),
                      ok ? bursts_q[0] : -1); end
    total++; if (data_err != 0 || exp_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL tmo_data: err=%0d left=%0d busy=%b want 0/0/0", data_err, exp_q.size(), busy); end
`ifdef FIL2DMA_BURST_STATS_EN
    total++; if (stat_timeouts !== tmo0 + 16'd1) begin
      bad++; $display("FAIL tmo_stat: got %0d want %0d", stat_timeouts, tmo0 + 16'd1); end
`endif
  endtask

  task automatic test_backpressure();
    bit ok = 0;
    clear_logs();
    cfg_en = 1'b1; dma_ready = 1'b1;
    for (int i = 0; i < 120 && !ok; i++) begin
      fifo_push = (i < BURST_LEN);
      fifo_din  = WIDTH'($urandom);
      @(negedge clk);
      dma_ready = ~dma_ready;
      ok = (bursts_q.size() >= 1);
    end
    fifo_push = 1'b0; dma_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (!ok || hs_cnt != BURST_LEN || bursts_q[0] != BURST_LEN) begin
      bad++; $display("FAIL bp_handshakes: got %0d want %0d", hs_cnt, BURST_LEN); end
    total++; if (stall_err != 0 || data_err != 0) begin
      bad++; $display("FAIL bp_hold: stall_err=%0d data_err=%0d want 0/0", stall_err, data_err); end
    total++; if (dut.occ !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_end: occ=%0d busy=%b want 0/0", dut.occ, busy); end
  endtask

  task automatic test_flush();
    bit ok;
    int busy_seen = 0;
    clear_logs();
    cfg_en = 1'b0; dma_ready = 1'b1;
    push_words(5);
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_noen: busy=%b want 0", busy); end
    pulse_flush();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_start: busy=%b want 1", busy); end
    wait_bursts(1, 30, ok);
    total++; if (!ok || bursts_q[0] != 5) begin
      bad++; $display("FAIL flush_len: got %0d want 5", ok ? bursts_q[0] : -1); end
    repeat (3) @(negedge clk);
    clear_logs();
    pulse_flush();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    total++; if (busy_seen != 0 || valid_cycles != 0) begin
      bad++; $display("FAIL flush_empty: busy=%0d valid=%0d want 0/0", busy_seen, valid_cycles); end
    push_words(10);
    pulse_flush();
    @(negedge clk);
    pulse_flush();
    wait_bursts(1, 40, ok);
    repeat (10) @(negedge clk);
    total++; if (!ok || bursts_q.size() != 1 || bursts_q[0] != BURST_LEN || dut.occ !== 6'd2) begin
      bad++; $display("FAIL flush_inburst: bursts=%0d occ=%0d want 1/2", bursts_q.size(), dut.occ); end
    pulse_flush();
    wait_bursts(2, 30, ok);
    total++; if (!ok || bursts_q[1] != 2 || data_err != 0) begin
      bad++; $display("FAIL flush_rest: got %0d err=%0d want 2/0", ok ? bursts_q[1] : -1, data_err); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_full_drop();
    bit ok = 1;
    bit step;
    clear_logs();
    cfg_en = 1'b0; dma_ready = 1'b1;
    push_words(DEPTH + 3);
    total++; if (int'(dut.occ) != DEPTH || fifo_full !== 1'b1) begin
      bad++; $display("FAIL drop_occ: got %0d want %0d", dut.occ, DEPTH); end
    for (int i = 0; i < DEPTH / BURST_LEN; i++) begin
      pulse_flush();
      wait_bursts(i + 1, 40, step);
      ok &= step;
      repeat (2) @(negedge clk);
    end
    total++; if (!ok || dut.occ !== '0 || exp_q.size() != 0 || data_err != 0) begin
      bad++; $display("FAIL drop_drain: occ=%0d left=%0d err=%0d want 0/0/0", dut.occ, exp_q.size(), data_err); end
    foreach (bursts_q[i]) begin
      total++; if (bursts_q[i] != BURST_LEN) begin
        bad++; $display("FAIL drop_len%0d: got %0d want %0d", i, bursts_q[i], BURST_LEN); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    cfg_en = 1'b1; dma_ready = 1'b1;
    push_words(20);
    wait_bursts(3, TIMEOUT + 120, ok);
    repeat (2) @(negedge clk);
    total++; if (!ok || bursts_q.size() != 3 || bursts_q[0] != 8 || bursts_q[1] != 8 || bursts_q[2] != 4) begin
      bad++; $display("FAIL b2b_lens: got %0d bursts (%0d,%0d,%0d) want 8,8,4", bursts_q.size(),
                      bursts_q.size() > 0 ? bursts_q[0] : -1, bursts_q.size() > 1 ? bursts_q[1] : -1,
                      bursts_q.size() > 2 ? bursts_q[2] : -1); end
    total++; if (occ_err != 0 || data_err != 0 || dut.occ !== '0) begin
      bad++; $display("FAIL b2b_occ: occ_err=%0d data_err=%0d occ=%0d want 0/0/0", occ_err, data_err, dut.occ); end
  endtask

  task automatic test_random();
    bit done = 0;
    int bad_len = 0;
    clear_logs();
    cfg_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      fifo_push = ($urandom_range(0, 99) < 40);
      fifo_din  = WIDTH'($urandom);
      dma_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    fifo_push = 1'b0; flush = 1'b0; dma_ready = 1'b1;
    for (int i = 0; i < 3 * TIMEOUT + 100 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy;
    end
    foreach (bursts_q[i]) if (bursts_q[i] < 1 || bursts_q[i] > BURST_LEN) bad_len++;
    total++; if (!done) begin bad++; $display("FAIL rnd_drain: left=%0d busy=%b want 0/0", exp_q.size(), busy); end
    total++; if (data_err != 0 || stall_err != 0 || occ_err != 0) begin
      bad++; $display("FAIL rnd_score: data=%0d stall=%0d occ=%0d want 0/0/0", data_err, stall_err, occ_err); end
    total++; if (bad_len != 0 || bursts_q.size() == 0) begin
      bad++; $display("FAIL rnd_lens: bad=%0d bursts=%0d want 0/>0", bad_len, bursts_q.size()); end
  endtask

  task automatic test_reset_midburst();
    bit ok = 0;
    clear_logs();
    cfg_en = 1'b1; dma_ready = 1'b1;
    push_words(BURST_LEN);
    for (int i = 0; i < 30 && !ok; i++) begin
      if (hs_cnt == 3) ok = 1;
      else @(negedge clk);
    end
    total++; if (!ok || dma_valid !== 1'b1) begin
      bad++; $display("FAIL mid_reach: hs=%0d valid=%b want 3/1", hs_cnt, dma_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (dma_valid !== 1'b0 || fifo_pop !== 1'b0 || busy !== 1'b0 || dma_last !== 1'b0) begin
      bad++; $display("FAIL mid_async: valid=%b pop=%b busy=%b last=%b want 0", dma_valid, fifo_pop, busy, dma_last); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (20) @(negedge clk);
    total++; if (valid_cycles != 0 || bursts_q.size() != 0 || busy !== 1'b0 || dut.occ !== '0) begin
      bad++; $display("FAIL mid_after: valid=%0d lasts=%0d busy=%b occ=%0d want 0", valid_cycles,
                      bursts_q.size(), busy, dut.occ); end
  endtask

  initial begin
    rst_n = 1'b1; cfg_en = 1'b0; flush = 1'b0; fifo_push = 1'b0;
    fifo_din = '0; dma_ready = 1'b1;
`ifdef FIL2DMA_BURST_STATS_EN
    stat_clr = 1'b0;
`endif
    #3 rst_n = 1'b0;
    test_reset();
    test_full_burst();
    test_timeout();
    test_backpressure();
    test_flush();
    test_full_drop();
    test_back_to_back();
    test_random();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
